// File: rtl/term_pkg.sv
// term_pkg: shared constants, control codes and state encoding
// for the character-cell VRAM writer.
package term_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 24;
    localparam int ROW_W    = 5;
    localparam int COL_W    = 7;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR_SCREEN,
        IDLE,
        CLEAR_LINE
    } state_t;

    // Printable range is space through tilde; DEL and above are not.
    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/term_writer_if.sv
// term_writer_if: byte-stream handshake plus VRAM write port.
// master = byte producer / VRAM, slave = the writer itself.
interface term_writer_if;
    import term_pkg::*;

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             write_ce;
    logic [ROW_W-1:0] write_row;
    logic [COL_W-1:0] write_col;
    logic [7:0]       write_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_ce,
        input  write_row,
        input  write_col,
        input  write_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_ce,
        output write_row,
        output write_col,
        output write_data
    );

endinterface

// File: rtl/row_wrap_add.sv
// row_wrap_add: (a + b) mod ROWS for inputs already below ROWS.
// Shared with the display read path to apply the scroll offset.
module row_wrap_add
    import term_pkg::*;
#(
    parameter int ROWS = ROWS_DEF
) (
    input  logic [ROW_W-1:0] i_a,
    input  logic [ROW_W-1:0] i_b,
    output logic [ROW_W-1:0] o_sum
);

    localparam logic [ROW_W:0] ROWS_EXT = (ROW_W + 1)'(ROWS);

    logic [ROW_W:0] w_sum;
    logic [ROW_W:0] w_sub;

    // Both operands are < ROWS, so one conditional subtract suffices.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub = w_sum - ROWS_EXT;
    assign o_sum = (w_sum >= ROWS_EXT) ? w_sub[ROW_W-1:0]
                                       : w_sum[ROW_W-1:0];

endmodule

// File: rtl/term_writer.sv
// term_writer: interprets a byte stream into VRAM character writes,
// tracks the cursor and scrolls by rotating the physical row offset.
module term_writer
    import term_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = CHR_SPACE
) (
    input  logic             clk,
    input  logic             reset_n,
    term_writer_if.slave     bus,
    output logic [ROW_W-1:0] scroll_row,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROW_W-1:0] r_scroll;
    logic [ROW_W-1:0] w_scroll_nxt;
    logic [ROW_W-1:0] r_cur_row;
    logic [ROW_W-1:0] w_cur_row_nxt;
    logic [COL_W-1:0] r_cur_col;
    logic [COL_W-1:0] w_cur_col_nxt;
    logic [ROW_W-1:0] r_clr_row;
    logic [ROW_W-1:0] w_clr_row_nxt;
    logic [COL_W-1:0] r_clr_col;
    logic [COL_W-1:0] w_clr_col_nxt;

    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_wce;
    logic             w_wce_nxt;
    logic [ROW_W-1:0] r_wrow;
    logic [ROW_W-1:0] w_wrow_nxt;
    logic [COL_W-1:0] r_wcol;
    logic [COL_W-1:0] w_wcol_nxt;
    logic [7:0]       r_wdata;
    logic [7:0]       w_wdata_nxt;

    logic [ROW_W-1:0] w_phys;
    logic [ROW_W-1:0] w_scroll_inc;
    logic             w_accept;
    logic             w_print;
    logic             w_is_cr;
    logic             w_is_lf;
    logic             w_is_bs;
    logic             w_wrap;
    logic             w_newline;
    logic             w_scroll_go;

    row_wrap_add #(.ROWS(ROWS)) u_phys (
        .i_a   (r_scroll),
        .i_b   (r_cur_row),
        .o_sum (w_phys)
    );

    row_wrap_add #(.ROWS(ROWS)) u_scroll_inc (
        .i_a   (r_scroll),
        .i_b   (ROW_ONE),
        .o_sum (w_scroll_inc)
    );

    // r_ready is only ever high in IDLE, so this implies the state.
    assign w_accept    = bus.in_valid && r_ready;
    assign w_print     = is_print(bus.in_data);
    assign w_is_cr     = (bus.in_data == CHR_CR);
    assign w_is_lf     = (bus.in_data == CHR_LF);
    assign w_is_bs     = (bus.in_data == CHR_BS);
    assign w_wrap      = w_print && (r_cur_col == COL_LAST);
    assign w_newline   = w_accept && (w_wrap || w_is_lf);
    assign w_scroll_go = w_newline && (r_cur_row == ROW_LAST);

    // State, cursor, scroll and clear-counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= CLEAR_SCREEN;
            r_scroll  <= '0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_clr_row <= '0;
            r_clr_col <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_scroll  <= w_scroll_nxt;
            r_cur_row <= w_cur_row_nxt;
            r_cur_col <= w_cur_col_nxt;
            r_clr_row <= w_clr_row_nxt;
            r_clr_col <= w_clr_col_nxt;
        end
    end

    // Next state: clear sweeps, byte interpretation, newline/scroll.
    always_comb begin
        w_state_nxt   = r_state;
        w_scroll_nxt  = r_scroll;
        w_cur_row_nxt = r_cur_row;
        w_cur_col_nxt = r_cur_col;
        w_clr_row_nxt = r_clr_row;
        w_clr_col_nxt = r_clr_col;
        unique case (r_state)
            CLEAR_SCREEN: begin
                if (r_clr_col == COL_LAST) begin
                    w_clr_col_nxt = '0;
                    if (r_clr_row == ROW_LAST) begin
                        w_clr_row_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_clr_row_nxt = r_clr_row + 1'b1;
                    end
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        w_print: begin
                            w_cur_col_nxt = w_wrap ? '0
                                          : r_cur_col + 1'b1;
                        end
                        w_is_cr: w_cur_col_nxt = '0;
                        w_is_bs: begin
                            if (r_cur_col != '0)
                                w_cur_col_nxt = r_cur_col - 1'b1;
                        end
                        default: ;
                    endcase
                    if (w_newline) begin
                        if (w_scroll_go) begin
                            // Old top row becomes the new bottom row.
                            w_scroll_nxt  = w_scroll_inc;
                            w_clr_row_nxt = r_scroll;
                            w_clr_col_nxt = '0;
                            w_state_nxt   = CLEAR_LINE;
                        end else begin
                            w_cur_row_nxt = r_cur_row + 1'b1;
                        end
                    end
                end
            end
            CLEAR_LINE: begin
                if (r_clr_col == COL_LAST) begin
                    w_clr_col_nxt = '0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_clr_col_nxt = r_clr_col + 1'b1;
                end
            end
            default: w_state_nxt = CLEAR_SCREEN;
        endcase
    end

    // Next outputs: blank fill during clears, char write on accept.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_wce_nxt   = 1'b0;
        w_wrow_nxt  = r_wrow;
        w_wcol_nxt  = r_wcol;
        w_wdata_nxt = r_wdata;
        unique case (r_state)
            CLEAR_SCREEN, CLEAR_LINE: begin
                w_wce_nxt   = 1'b1;
                w_wrow_nxt  = r_clr_row;
                w_wcol_nxt  = r_clr_col;
                w_wdata_nxt = BLANK;
            end
            IDLE: begin
                // Drop ready immediately when a scroll is starting.
                w_ready_nxt = !w_scroll_go;
                if (w_accept && w_print) begin
                    w_wce_nxt   = 1'b1;
                    w_wrow_nxt  = w_phys;
                    w_wcol_nxt  = r_cur_col;
                    w_wdata_nxt = bus.in_data;
                end
            end
            default: ;
        endcase
    end

    // Registered handshake and VRAM write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready <= 1'b0;
            r_wce   <= 1'b0;
            r_wrow  <= '0;
            r_wcol  <= '0;
            r_wdata <= '0;
        end else begin
            r_ready <= w_ready_nxt;
            r_wce   <= w_wce_nxt;
            r_wrow  <= w_wrow_nxt;
            r_wcol  <= w_wcol_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.write_ce   = r_wce;
    assign bus.write_row  = r_wrow;
    assign bus.write_col  = r_wcol;
    assign bus.write_data = r_wdata;
    assign scroll_row     = r_scroll;
    assign cursor_row     = r_cur_row;
    assign cursor_col     = r_cur_col;

endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: randomized byte stream against a screen-level model;
// expected VRAM writes are queued and checked by a negedge monitor.
module tb_term_writer;
    import term_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 24;

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] scroll_row;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    term_writer_if bus();

    term_writer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .BLANK (8'h20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .scroll_row (scroll_row),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_cmp   = 0;
    int  n_bad   = 0;
    int  n_pulse = 0;
    int  n_waits = 0;
    int  m_row   = 0;
    int  m_col   = 0;
    int  m_scroll = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int r, input int c, input int d);
        wr_t w;
        w.row  = r;
        w.col  = c;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Screen model: scroll exposes the old top row, which gets blanked.
    task automatic m_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int c = 0; c < COLS; c++) push_wr(m_scroll, c, 32);
            m_scroll = (m_scroll + 1) % ROWS;
        end
    endtask

    task automatic m_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr((m_scroll + m_row) % ROWS, m_col, int'(b));
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_newline();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end
    endtask

    task automatic m_reset();
        m_row    = 0;
        m_col    = 0;
        m_scroll = 0;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                push_wr(r, c, 32);
    endtask

    // Scoreboard monitor: every write strobe must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (bus.write_ce === 1'b1) begin
            n_pulse++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_write: got r%0d c%0d d%02h, want none",
                         bus.write_row, bus.write_col, bus.write_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.write_row) != e.row ||
                    int'(bus.write_col) != e.col ||
                    int'(bus.write_data) != e.data) begin
                    n_bad++;
                    $display("FAIL vram_write: got r%0d c%0d d%02h, want r%0d c%0d d%02h",
                             bus.write_row, bus.write_col, bus.write_data,
                             e.row, e.col, e.data);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (bus.in_ready !== 1'b1) n_waits++;
        while (bus.in_ready !== 1'b1 && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 5000) begin
            chk("send_timeout", guard, 0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            m_accept(b);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic count_low(output int low);
        low = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && low < 5000) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.in_ready !== 1'b1) && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_state(input string name);
        chk({name, "_crow"}, int'(cursor_row), m_row);
        chk({name, "_ccol"}, int'(cursor_col), m_col);
        chk({name, "_scroll"}, int'(scroll_row), m_scroll);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", int'(bus.in_ready), 0);
        chk("rst_wce", int'(bus.write_ce), 0);
        chk("rst_wrow", int'(bus.write_row), 0);
        chk("rst_wcol", int'(bus.write_col), 0);
        chk("rst_wdata", int'(bus.write_data), 0);
        chk_state("rst");
    endtask

    initial begin
        int          low;
        int          r;
        logic [7:0]  b;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // 1: reset, full-screen clear
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        n_pulse = 0;
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        count_low(low);
        chk("clear_ready_low", low, ROWS * COLS);
        drain("clear_drain");
        chk("clear_pulses", n_pulse, ROWS * COLS);

        // 2: single char and its latency
        send(8'h41);
        @(negedge clk);
        chk("A_latency", int'(bus.write_ce), 1);
        drain("A_drain");
        chk_state("A");

        // 3: full row burst, wrap to next line
        send(8'h0D);
        drain("burst_pre");
        n_waits = 0;
        for (int i = 0; i < COLS; i++) begin
            b = 8'($urandom_range(32, 126));
            send(b);
        end
        chk("burst_stalls", n_waits, 0);
        drain("burst_drain");
        chk_state("burst");

        // 4: BS at col 0, then "AB" BS 'C' CR LF
        send(8'h08);
        send(8'h41);
        send(8'h42);
        send(8'h08);
        send(8'h43);
        send(8'h0D);
        send(8'h0A);
        drain("ctl_drain");
        chk_state("ctl");

        // 5: LF on bottom row scrolls and blanks one line
        while (m_row < ROWS - 1) send(8'h0A);
        drain("bottom_drain");
        send(8'h0A);
        count_low(low);
        chk("scroll_ready_low", low, COLS + 1);
        drain("scroll_drain");
        chk_state("scroll");
        send(8'h58);
        drain("X_drain");
        chk_state("X");

        // randomized stream, includes wraps and scrolls
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else b = 8'($urandom_range(0, 255));
            send(b);
        end
        drain("rand_drain");
        chk_state("rand");

        // 6: reset in the middle of a line clear
        while (m_row < ROWS - 1) send(8'h0A);
        send(8'h0A);
        repeat (40) @(negedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
        n_pulse = 0;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        count_low(low);
        chk("reclear_ready_low", low, ROWS * COLS);
        drain("reclear_drain");
        chk("reclear_pulses", n_pulse, ROWS * COLS);
        chk_state("reclear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
